// File: rtl/alu_issue_regfile_if.sv
// Instruction, ALU operand/result and writeback signals of the ALU issue stage.
// Latency: none, plain signal bundle.
// Backpressure: in_valid/in_ready handshake on the instruction side; writeback is a pulse with no stall.
interface alu_issue_regfile_if #(
   parameter int WIDTH = 64,
   parameter int AW    = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic [AW-1:0]    in_rd;
   logic [AW-1:0]    in_rs1;
   logic [AW-1:0]    in_rs2;
   logic [WIDTH-1:0] in_imm;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   logic             wb_valid;
   logic [AW-1:0]    wb_rd;
   logic [WIDTH-1:0] wb_data;

   // Upstream instruction source, ALU and writeback observer side.
   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
      input  in_ready,
      input  alu_a, alu_b, alu_op,
      output alu_result, alu_carry,
      input  wb_valid, wb_rd, wb_data
   );

   // Issue stage side.
   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
      output in_ready,
      output alu_a, alu_b, alu_op,
      input  alu_result, alu_carry,
      output wb_valid, wb_rd, wb_data
   );
endinterface

// File: rtl/alu_issue_regfile.sv
// Operand fetch / writeback stage with a small register file in front of a combinational 64-bit ALU.
// Latency: ALU op writes 1 edge after accept, wb_valid the cycle after; LOADI writes at accept. Re-accept after 3 (ALU) / 2 (LOADI) cycles.
// Backpressure: in_ready is high only in IDLE; one instruction in flight, no overlap so no hazards.
// Optional: define ALU_ZERO_FLAG_EN to add the zero_flag output.
module alu_issue_regfile #(
   parameter int WIDTH = 64,
   parameter int AW    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_issue_regfile_if.slave   bus,
   output logic                 carry_flag,
   output logic                 div0_err,
   input  logic [AW-1:0]        dbg_addr,
   output logic [WIDTH-1:0]     dbg_data
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic                 zero_flag
`endif
);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_LOADI = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // Instruction fields that must survive past the accept edge.
   typedef struct packed {
      logic [3:0]    op;
      logic [AW-1:0] rd;
   } meta_t;

   state_t           state_q;
   state_t           state_d;
   meta_t            meta_q;
   logic [WIDTH-1:0] rf [2**AW];

   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [3:0]       alu_op_q;
   logic             wb_valid_q;
   logic [AW-1:0]    wb_rd_q;
   logic [WIDTH-1:0] wb_data_q;
   logic             carry_q;
   logic             div0_q;
   logic             in_ready_c;

   logic             accept;
   logic             is_loadi;
   logic             div0_hit;
   logic [WIDTH-1:0] rs1_val;
   logic [WIDTH-1:0] rs2_val;

`ifdef ALU_ZERO_FLAG_EN
   logic             zero_q;
   assign zero_flag = zero_q;
`endif

   // Operands come from the register state as it stands at the accept edge.
   assign rs1_val  = rf[bus.in_rs1];
   assign rs2_val  = rf[bus.in_rs2];
   assign accept   = bus.in_valid && (state_q == S_IDLE);
   assign is_loadi = (bus.in_op == OP_LOADI);
   // A DIV whose divisor register is zero is screened out before reaching the ALU.
   assign div0_hit = accept && (bus.in_op == OP_DIV) && (rs2_val == '0);

   assign bus.in_ready = in_ready_c;
   assign bus.alu_a    = alu_a_q;
   assign bus.alu_b    = alu_b_q;
   assign bus.alu_op   = alu_op_q;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_rd    = wb_rd_q;
   assign bus.wb_data  = wb_data_q;
   assign carry_flag   = carry_q;
   assign div0_err     = div0_q;
   assign dbg_data     = rf[dbg_addr];

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      state_d    = state_q;
      in_ready_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               if (is_loadi) begin
                  state_d = S_WB;
               end else if (div0_hit) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: operand launch, result capture, register file write and status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < (1 << AW); i++) begin
            rf[i] <= '0;
         end
         meta_q     <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         carry_q    <= 1'b0;
         div0_q     <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
         zero_q     <= 1'b0;
`endif
      end else begin
         // wb_valid is a single-cycle pulse; only the write edges raise it.
         wb_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  meta_q <= '{op: bus.in_op, rd: bus.in_rd};
                  // Any accepted instruction clears the sticky flag; a rejected DIV re-sets it.
                  div0_q <= div0_hit;
                  if (is_loadi) begin
                     rf[bus.in_rd] <= bus.in_imm;
                     wb_valid_q    <= 1'b1;
                     wb_rd_q       <= bus.in_rd;
                     wb_data_q     <= bus.in_imm;
`ifdef ALU_ZERO_FLAG_EN
                     zero_q        <= (bus.in_imm == '0);
`endif
                  end else if (!div0_hit) begin
                     alu_a_q  <= rs1_val;
                     alu_b_q  <= rs2_val;
                     alu_op_q <= bus.in_op;
                  end
               end
            end
            S_EXEC: begin
               rf[meta_q.rd] <= bus.alu_result;
               wb_valid_q    <= 1'b1;
               wb_rd_q       <= meta_q.rd;
               wb_data_q     <= bus.alu_result;
               if (meta_q.op == OP_ADD) begin
                  carry_q <= bus.alu_carry;
               end
`ifdef ALU_ZERO_FLAG_EN
               zero_q        <= (bus.alu_result == '0);
`endif
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/alu_issue_regfile.md
Name: alu_issue_regfile

Overview:
- Upstream operand and writeback stage for the 64-bit combinational ALU.
- Holds a small general-purpose register file and accepts one instruction at a time over a valid/ready handshake.
- Reads operands from the register file, drives the ALU inputs from registers, captures the ALU result and carry-out, and writes the result back to the destination register.
- Also handles load-immediate and divide-by-zero screening.

Parameters:
- WIDTH, 64, datapath width; matches the ALU operands and result.
- AW, 3, register address width; register file has 2**AW entries.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept an instruction
- in_op  in  4  opcode
- in_rd  in  AW  destination register
- in_rs1  in  AW  source register A
- in_rs2  in  AW  source register B
- in_imm  in  WIDTH  immediate, used only by LOADI
- alu_a  out  WIDTH  registered ALU first operand
- alu_b  out  WIDTH  registered ALU second operand
- alu_op  out  4  registered ALU operation
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_carry  in  1  ALU carry-out of a+b
- wb_valid  out  1  one-cycle pulse: register written this cycle
- wb_rd  out  AW  register written
- wb_data  out  WIDTH  value written
- carry_flag  out  1  carry from last executed ADD
- div0_err  out  1  sticky divide-by-zero flag
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  combinational read of regfile[dbg_addr]

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 1000 AND, 1001 OR, 1010 XOR, 1111 LOADI.
  - All other codes are forwarded to the ALU unchanged; no special handling in this stage.
- Reset (rst_n=0 at a rising edge):
  - All registers cleared to 0; state=IDLE.
  - alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, carry_flag and div0_err all 0.
  - in_ready=1 in the first cycle after reset.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch rd and op.
  - LOADI: write in_imm to rd at this edge → WB.
  - DIV with regfile[rs2]==0: set div0_err, no write, stay IDLE.
  - Otherwise: load alu_a=regfile[rs1], alu_b=regfile[rs2], alu_op=in_op → EXEC.
- EXEC:
  - in_ready=0.
  - At the edge, capture alu_result into the write register; if op==ADD, carry_flag<=alu_carry.
  - Write the result to regfile[rd] → WB.
- WB:
  - in_ready=0; wb_valid=1 for exactly one cycle with wb_rd and wb_data = written value → IDLE.
- Latency:
  - ALU op: accept edge, +1 edge writes result, wb_valid high in the following cycle. Next instruction can be accepted 3 cycles after the previous one.
  - LOADI: write at the accept edge; wb_valid in the next cycle; re-accept 2 cycles later.
- Operand reads use the register state at the accept edge. No overlap, so no hazards; rd==rs1==rs2 is legal.
- Register contents:
  - alu_a, alu_b and alu_op hold their last values outside EXEC.
  - wb_rd and wb_data hold their values after wb_valid drops.
- div0_err:
  - Set on a rejected DIV; cleared when any later instruction is accepted.
  - Setting has priority if both conditions occur on the same edge.
- carry_flag is unchanged by non-ADD ops and by LOADI.
- dbg_data reflects a write on the cycle after the write edge.
- Reset mid-operation: the instruction is abandoned, no writeback occurs, and all state clears.
- Widths: operands and results are WIDTH bits. MUL and DIV results are truncated by the ALU; this stage does not check for overflow.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN
- With the macro defined:
  - Adds output zero_flag (1 bit, reset 0).
  - Updated at every result write: 1 if the written value (ALU result or LOADI immediate) is all zeros.
  - Unchanged on a rejected DIV.
- Without the macro: the port and its logic are absent.

Test Plan:
- Reset then LOADI r1=5, LOADI r2=3, ADD rd=r3 rs1=r1 rs2=r2 → wb_valid with wb_rd=3 and wb_data=8; alu_a=5 and alu_b=3 during EXEC; carry_flag=0; dbg_addr=3 → 8.
- LOADI r1=0xFFFF_FFFF_FFFF_FFFF, LOADI r2=1, ADD r3 → wb_data=0, carry_flag=1; then XOR r4=r1^r2 → wb_data=0xFFFF_FFFF_FFFF_FFFE, carry_flag still 1.
- LOADI r2=0, DIV r5=r1/r2 → div0_err=1, no wb_valid, r5 unchanged, in_ready=1 the next cycle; a subsequent SUB clears div0_err.
- Hold in_valid=1 continuously with 4 ALU ops → each accepted exactly 3 cycles apart, in_ready=0 in EXEC and WB, one wb_valid per op.
- Drive rst_n=0 during EXEC of MUL r6=7*6 → no wb_valid; all registers read 0 after reset; carry_flag=0.
- With ALU_ZERO_FLAG_EN defined, SUB r7=r1-r1 (r1=9) → zero_flag=1; next LOADI r7=2 → zero_flag=0.
